// File: rtl/ser_arb_pkg.sv
// ser_arb_pkg: shared types and constants for the serializer link arbiter.
//   arb_state_t  - arbiter FSM state encoding
//   HDR_MAGIC    - upper five bits of the optional header byte
//   DEF_BIT_TIME - default serializer bit-time in clock cycles
//   hdr_byte()   - builds the header byte for a requester id
package ser_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR_LOAD  = 3'd1,
        HDR_SHIFT = 3'd2,
        LOAD      = 3'd3,
        SHIFT     = 3'd4
    } arb_state_t;

    localparam logic [4:0]  HDR_MAGIC    = 5'b10100;
    localparam int unsigned DEF_BIT_TIME = 8;

    function automatic logic [7:0] hdr_byte(input logic [2:0] id);
        return {HDR_MAGIC, id};
    endfunction

endpackage

// File: rtl/ser_link_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection.
//   req_valid  - per-requester valid
//   ptr        - index of the last granted requester
//   win_onehot - one-hot winner (zero when nothing is valid)
//   win_idx    - winner index
//   any_valid  - at least one requester is valid
// The search starts at ptr+1 and wraps modulo NREQ, so the last winner has
// the lowest priority in the next round.
module rr_picker #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win_onehot,
    output logic [IW-1:0]   win_idx,
    output logic            any_valid
);

    int unsigned   cand;
    logic [IW-1:0] cidx;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        any_valid  = 1'b0;
        cand       = 0;
        cidx       = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = (32'(ptr) + i) % NREQ;
            cidx = IW'(cand);
            if (!any_valid && req_valid[cidx]) begin
                any_valid        = 1'b1;
                win_idx          = cidx;
                win_onehot[cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ser_link_arbiter.sv
// ser_link_arbiter: round-robin arbiter sharing one 8-bit serializer link
// among NREQ byte requesters. One byte is accepted per grant, presented to
// the serializer with a one-cycle load strobe, and the link is then held for
// BIT_TIME cycles before the next arbitration.
//   clk, reset - rising-edge clock, asynchronous active-high reset
//   req_valid  - per-requester byte valid
//   req_data   - requester i byte on bits [8i+7:8i]
//   req_ready  - combinational one-hot accept pulse (IDLE only)
//   ser_data   - byte to serializer, qualified by ser_load
//   ser_load   - one-cycle load strobe
//   link_busy  - high whenever the FSM is not in IDLE
//   grant_id   - index of the current or last granted requester
// Build option: define SER_HDR_EN to send a header byte {HDR_MAGIC, id}
// ahead of every data byte.
module ser_link_arbiter
    import ser_arb_pkg::*;
#(
    parameter  int unsigned NREQ     = 4,
    parameter  int unsigned BIT_TIME = DEF_BIT_TIME,
    localparam int unsigned IW       = $clog2(NREQ),
    localparam int unsigned CW       = $clog2(BIT_TIME + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        ser_data,
    output logic              ser_load,
    output logic              link_busy,
    output logic [IW-1:0]     grant_id
);

    arb_state_t      state, next_state;
    logic [IW-1:0]   ptr, ptr_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [7:0]      ser_data_d;
    logic            ser_load_d, link_busy_d;
    logic [IW-1:0]   grant_id_d;

    logic [NREQ-1:0] win_onehot;
    logic [IW-1:0]   win_idx;
    logic            any_valid;
    logic [7:0]      win_byte;
    logic            grant;
    logic            cnt_last;

`ifdef SER_HDR_EN
    logic [7:0]      data_q, data_q_d;
`endif

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req_valid  (req_valid),
        .ptr        (ptr),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any_valid  (any_valid)
    );

    always_comb begin
        win_byte = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_onehot[i]) win_byte = req_data[8*i +: 8];
        end
    end

    assign grant    = (state == IDLE) && any_valid;
    assign cnt_last = (cnt == CW'(BIT_TIME - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_valid) begin
`ifdef SER_HDR_EN
                    next_state = HDR_LOAD;
`else
                    next_state = LOAD;
`endif
                end
            end
`ifdef SER_HDR_EN
            HDR_LOAD:  next_state = HDR_SHIFT;
            HDR_SHIFT: if (cnt_last) next_state = LOAD;
`endif
            LOAD:      next_state = SHIFT;
            SHIFT:     if (cnt_last) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Output logic: req_ready is combinational; the rest are next values of
    // registered outputs, derived from next_state so they line up with it.
    always_comb begin
        req_ready   = (state == IDLE && !reset) ? win_onehot : '0;
        ptr_d       = grant ? win_idx : ptr;
        grant_id_d  = grant ? win_idx : grant_id;
        ser_load_d  = (next_state == LOAD) || (next_state == HDR_LOAD);
        link_busy_d = (next_state != IDLE);
        ser_data_d  = ser_data;

        cnt_d = cnt;
        case (state)
            LOAD, HDR_LOAD:  cnt_d = '0;
            SHIFT, HDR_SHIFT: cnt_d = cnt_last ? '0 : cnt + 1'b1;
            default:         cnt_d = cnt;
        endcase

`ifdef SER_HDR_EN
        data_q_d = grant ? win_byte : data_q;
        if (next_state == HDR_LOAD) ser_data_d = hdr_byte(3'(win_idx));
        else if (next_state == LOAD) ser_data_d = data_q;
`else
        if (grant) ser_data_d = win_byte;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= IW'(NREQ - 1);
            cnt       <= '0;
            ser_data  <= '0;
            ser_load  <= 1'b0;
            link_busy <= 1'b0;
            grant_id  <= '0;
        end else begin
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            ser_data  <= ser_data_d;
            ser_load  <= ser_load_d;
            link_busy <= link_busy_d;
            grant_id  <= grant_id_d;
        end
    end

`ifdef SER_HDR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else       data_q <= data_q_d;
    end
`endif

endmodule

// File: tb/tb_ser_link_arbiter.sv
module tb_ser_link_arbiter;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned BIT_TIME = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        ser_data;
    logic              ser_load;
    logic              link_busy;
    logic [1:0]        grant_id;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ser_link_arbiter #(.NREQ(NREQ), .BIT_TIME(BIT_TIME)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ser_data  (ser_data),
        .ser_load  (ser_load),
        .link_busy (link_busy),
        .grant_id  (grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enter the next cycle and leave room to drive inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Sample point, half a cycle away from the active edge.
    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        smp();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_data",  32'(ser_data),  32'h0);
        chk("rst_load",  32'(ser_load),  32'h0);
        chk("rst_busy",  32'(link_busy), 32'h0);
        chk("rst_gid",   32'(grant_id),  32'h0);
        cyc();
        reset = 1'b0;

`ifdef SER_HDR_EN
        // Header mode: requester 2 sends 8'hC3
        cyc();
        req_valid = 4'b0100;
        req_data  = 32'h00C3_0000;
        smp();
        chk("hdr_ready", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        smp();
        chk("hdr_load1", 32'(ser_load), 32'h1);
        chk("hdr_byte",  32'(ser_data), 32'hA2);
        chk("hdr_gid",   32'(grant_id), 32'h2);
        for (int c = 2; c <= 9; c++) begin
            cyc(); smp();
            chk("hdr_shift_load", 32'(ser_load),  32'h0);
            chk("hdr_shift_busy", 32'(link_busy), 32'h1);
        end
        cyc(); smp();
        chk("hdr_load2", 32'(ser_load), 32'h1);
        chk("hdr_data",  32'(ser_data), 32'hC3);
        for (int c = 11; c <= 18; c++) begin
            cyc(); smp();
            chk("dat_shift_load", 32'(ser_load),  32'h0);
            chk("dat_shift_busy", 32'(link_busy), 32'h1);
        end
        cyc(); smp();
        chk("hdr_idle", 32'(link_busy), 32'h0);
`else
        // Single request from requester 1
        cyc();
        req_valid = 4'b0010;
        req_data  = 32'h0000_5A00;
        smp();
        chk("single_ready", 32'(req_ready), 32'h2);
        chk("single_busy0", 32'(link_busy), 32'h0);
        cyc();
        req_valid = '0;
        smp();
        chk("single_load",   32'(ser_load),  32'h1);
        chk("single_data",   32'(ser_data),  32'h5A);
        chk("single_busy1",  32'(link_busy), 32'h1);
        chk("single_gid",    32'(grant_id),  32'h1);
        chk("single_noready",32'(req_ready), 32'h0);
        for (int c = 2; c <= 9; c++) begin
            cyc(); smp();
            chk("single_shift_busy", 32'(link_busy), 32'h1);
            chk("single_shift_load", 32'(ser_load),  32'h0);
        end
        cyc(); smp();
        chk("single_idle_busy", 32'(link_busy), 32'h0);
        chk("single_idle_load", 32'(ser_load),  32'h0);
        chk("single_idle_data", 32'(ser_data),  32'h5A);
        chk("single_idle_gid",  32'(grant_id),  32'h1);

        // All valid: round-robin 0,1,2,3 from a fresh reset, 10 cycles apart
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        req_valid = 4'b1111;
        req_data  = 32'h4433_2211;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("rr_ready", 32'(req_ready), 32'(1 << k));
            cyc(); smp();
            chk("rr_load", 32'(ser_load), 32'h1);
            chk("rr_gid",  32'(grant_id), 32'(k));
            chk("rr_data", 32'(ser_data), 32'h11 * 32'(k + 1));
            for (int j = 2; j <= 9; j++) begin
                cyc(); smp();
                chk("rr_gap_load", 32'(ser_load), 32'h0);
            end
            cyc();
        end

        // Fairness: after 3, {3,0} valid -> 0; after 0 -> 3
        req_valid = 4'b1001;
        smp();
        chk("fair_ready0", 32'(req_ready), 32'h1);
        cyc(); smp();
        chk("fair_gid0",  32'(grant_id), 32'h0);
        chk("fair_load0", 32'(ser_load), 32'h1);
        chk("fair_data0", 32'(ser_data), 32'h11);
        for (int j = 2; j <= 9; j++) begin
            cyc(); smp();
        end
        cyc(); smp();
        chk("fair_ready3", 32'(req_ready), 32'h8);
        cyc();
        req_valid = '0;
        smp();
        chk("fair_gid3",  32'(grant_id), 32'h3);
        chk("fair_data3", 32'(ser_data), 32'h44);
        chk("fair_load3", 32'(ser_load), 32'h1);

        // Late arrival of requester 2 during SHIFT
        cyc();
        cyc();
        req_valid = 4'b0100;
        smp();
        chk("late_wait", 32'(req_ready), 32'h0);
        for (int j = 4; j <= 9; j++) begin
            cyc(); smp();
            chk("late_wait", 32'(req_ready), 32'h0);
        end
        cyc(); smp();
        chk("late_ready", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        smp();
        chk("late_gid",  32'(grant_id), 32'h2);
        chk("late_data", 32'(ser_data), 32'h33);
        chk("late_load", 32'(ser_load), 32'h1);

        // Reset at SHIFT count 4, then requester 0 wins over 2
        for (int j = 2; j <= 6; j++) cyc();
        smp();
        chk("mid_busy_pre", 32'(link_busy), 32'h1);
        cyc();
        reset     = 1'b1;
        req_valid = 4'b0101;
        smp();
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_data",  32'(ser_data),  32'h0);
        chk("mid_rst_load",  32'(ser_load),  32'h0);
        chk("mid_rst_busy",  32'(link_busy), 32'h0);
        chk("mid_rst_gid",   32'(grant_id),  32'h0);
        cyc();
        reset = 1'b0;
        smp();
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        cyc(); smp();
        chk("post_rst_gid",  32'(grant_id), 32'h0);
        chk("post_rst_load", 32'(ser_load), 32'h1);
        chk("post_rst_data", 32'(ser_data), 32'h11);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ser_link_arbiter.md
# ser_link_arbiter

Round-robin arbiter and sequencer that shares one 8-bit serializer link among up to eight byte requesters. It accepts one byte per grant and issues a one-cycle load strobe to the serializer. It then holds the link for the byte's bit-time before re-arbitrating. It sits in front of the serializer input, in place of a single hard-wired byte source.

## Interface
- NREQ, 4: number of requesters, legal 2..8
- BIT_TIME, 8: clock cycles the serializer needs to shift out one loaded byte, legal 2..255
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  per-requester byte valid
- req_data  input  NREQ*8  requester i byte on bits [8i+7:8i]
- req_ready  output  NREQ  one-hot accept pulse; a transfer occurs when valid & ready
- ser_data  output  8  byte presented to serializer, qualified by ser_load
- ser_load  output  1  one-cycle load strobe to serializer
- link_busy  output  1  high whenever the FSM is not in IDLE
- grant_id  output  $clog2(NREQ)  index of the current or last granted requester

## Operation
- States: IDLE, HDR_LOAD, HDR_SHIFT (the HDR states exist only with the macro), LOAD, SHIFT.
- IDLE behaviour:
  - If any req_valid is high, pick the winner round-robin, searching upward from ptr+1 modulo NREQ.
  - req_ready[winner] is combinational and high in this cycle only.
  - Latch req_data of the winner and set grant_id and ptr to the winner.
  - Go to LOAD, or to HDR_LOAD if the header is enabled.
- LOAD: ser_load=1 and ser_data=latched byte. Clear the bit counter and go to SHIFT.
- SHIFT: count BIT_TIME cycles. At count==BIT_TIME-1, go to IDLE.
- Requester rules:
  - Requesters hold req_valid and data stable until ready.
  - req_ready never asserts outside IDLE.
  - Deasserting valid before ready is legal and drops that request without penalty.
- No valid in IDLE: stay in IDLE and keep all outputs unchanged except req_ready=0.
- Counter is $clog2(BIT_TIME+1) bits. It never wraps within a byte.
- Reset values:
  - state=IDLE, ptr=NREQ-1 (so requester 0 has first priority).
  - req_ready=0, ser_data=8'h00, ser_load=0, link_busy=0, grant_id=0, counter=0.
- Reset during any state aborts the byte immediately. The serializer's partial output is not the arbiter's concern.

## Timing
- Request accepted in cycle t:
  - ser_load in t+1.
  - SHIFT occupies t+2..t+BIT_TIME+1.
  - IDLE in t+BIT_TIME+2.
- Sustained throughput is one byte per BIT_TIME+2 cycles, with a single IDLE arbitration cycle between bytes.
- ser_load, ser_data, grant_id and link_busy are registered. req_ready is combinational from state, ptr and req_valid.

## Configuration
- SER_HDR_EN defined: each grant sends a header byte before the data byte.
  - Header is {5'b10100, id} with the id zero-extended to 3 bits, e.g. 8'hA2 for requester 2.
  - Sequence is IDLE → HDR_LOAD (ser_load, header) → HDR_SHIFT (BIT_TIME) → LOAD → SHIFT → IDLE.
  - Period is 2*BIT_TIME+3 cycles.
- SER_HDR_EN undefined: HDR states and header logic are absent, and the period is BIT_TIME+2.

## Structure
- Package ser_arb_pkg holds:
  - the state enum;
  - the HDR_MAGIC constant 5'b10100;
  - the default BIT_TIME.
- Sub-module rr_picker is purely combinational. It takes req_valid and ptr and returns a one-hot winner, its index and an any-valid flag.

## Test plan
Defaults NREQ=4 and BIT_TIME=8 unless noted.
- Single request: req_valid=4'b0010 and byte1=8'h5A at cycle 0.
  - req_ready=4'b0010 in cycle 0.
  - ser_load=1 with ser_data=8'h5A in cycle 1.
  - link_busy high in cycles 1..9, IDLE in cycle 10.
- All valid continuously with bytes 8'h11, 8'h22, 8'h33, 8'h44.
  - grant_id sequence is 0, 1, 2, 3, 0.
  - ser_load pulses occur exactly 10 cycles apart.
- Fairness: after requester 3 is served, req_valid=4'b1001 → requester 0 wins. After requester 0 is served, with 4'b1001 still high → requester 3 wins.
- Late arrival: req_valid[2] rises in SHIFT → req_ready[2] stays 0 until the next IDLE cycle, then pulses.
- Reset mid-SHIFT at count 4.
  - All outputs read 0 in the same cycle.
  - After release, req_valid=4'b0101 → requester 0 wins.
- SER_HDR_EN with requester 2 sending 8'hC3.
  - ser_load with 8'hA2 at cycle 1.
  - ser_load with 8'hC3 at cycle 10.
  - IDLE at cycle 19.
